eth_rx_frame_buf: RTL and testbench
===================================

# eth_rx_frame_buf

Multi-slot Ethernet receive frame buffer with an AXI4-Lite slave port. It sits between the MAC receive datapath and the processor interconnect. Incoming frames are written word-by-word into a ring of fixed-size slots. Software reads each completed frame through a memory-mapped data window, then frees the slot through a release register.

## Interface
- C_DATA_WIDTH, 32, data word width; 32 or 64.
- C_DEPTH, 512, words per slot; power of two.
- C_NUM_SLOTS, 4, frame slots; power of two, 2..16.
- C_ADDR_WIDTH (localparam), $clog2(C_NUM_SLOTS*C_DEPTH)+$clog2(C_DATA_WIDTH/8)+1; MSB set selects register space.
- s_axi_aclk  in  1  single clock for all logic.
- s_axi_aresetn  in  1  asynchronous active-low reset.
- s_axi_aw{addr,prot,valid}/awready, s_axi_w{data,strb,valid}/wready, s_axi_b{resp,valid}/bready  standard AXI4-Lite write channels, C_ADDR_WIDTH / C_DATA_WIDTH.
- s_axi_ar{addr,prot,valid}/arready, s_axi_r{data,resp,valid}/rready  standard AXI4-Lite read channels.
- eth_rx_data  in  C_DATA_WIDTH  receive word.
- eth_rx_valid  in  1  word qualifier; no backpressure.
- eth_rx_last  in  1  final word of frame, qualified by valid.
- eth_rx_err  in  1  frame bad (FCS/PHY); sampled with last.
- irq  out  1  frame-available interrupt.

## Operation
- Register map (byte offsets in register space):
  - 0x0 STATUS (RO): [C_NUM_SLOTS-1:0] slot-full flags; [19:16] head slot; [27:24] write slot.
  - 0x4 LEN (RO): head slot length in words; 0 if the head slot is empty.
  - 0x8 RELEASE (WO): any write frees the head slot and advances head.
  - 0xC DROPS (RO): saturating 32-bit count of dropped frames.
- Data window: word address bits select the slot (upper) and the word (lower). Reads return the RAM word; write contents are not defined.
- Write FSM has three states: IDLE, FILL, DISCARD.
  - IDLE, valid, slot free: store the word at offset 0 and go to FILL. If that word is also last, commit immediately.
  - IDLE, valid, write slot full: go to DISCARD and count a drop.
  - FILL: store the word and increment the pointer. On last with err=0: commit (length=ptr+1, set full, write slot +1 mod C_NUM_SLOTS) and go to IDLE. On last with err=1: count a drop and go to IDLE without committing.
  - FILL, word C_DEPTH arrives without last: truncate. Go to DISCARD, count a drop, do not commit.
  - DISCARD: ignore words until last, then go to IDLE.
- Release with no full slot: ignored, bresp SLVERR.
- Commit and release in the same cycle both take effect, including when they target the same full/empty bookkeeping.
- Write to the data window or a RO register: SLVERR, no effect. Unmapped register read: SLVERR, rdata 0. All other accesses return OKAY.
- DROPS saturates at 0xFFFFFFFF.

## Timing
- Reset values: all ready/valid outputs 0, rdata 0, resp 0, irq 0, slot flags 0, pointers 0, DROPS 0, FSM in IDLE. RAM contents are not reset.
- Read channel: arready pulses for 1 cycle, the cycle after arvalid is sampled with no read outstanding.
  - rvalid rises 2 cycles after the handshake (RAM read, then output register).
  - rvalid and rdata hold until rready. A new AR is not accepted while rvalid=1.
- Write channel: awready and wready pulse together once both valids are seen. bvalid follows 1 cycle later and holds until bready.
- Stream side: one word per cycle, sustained. A commit is visible in STATUS/LEN on the cycle after last.
- Reset mid-frame: the partial frame is lost and the FSM returns to IDLE.

## Configuration
- ETH_RX_IRQ_EN defined: irq is a registered output, high while any slot-full flag is set.
- ETH_RX_IRQ_EN undefined: irq is tied to 0 and no logic is generated for it.

## Structure
- Package eth_rx_pkg holds:
  - the write FSM state enum;
  - register offsets;
  - resp codes (OKAY, SLVERR).
- Sub-module eth_rx_slot_ram: simple dual-port RAM with one write port and one registered read port, C_NUM_SLOTS*C_DEPTH words.

## Test plan
- Frame of 5 words 0x11..0x15, last on the 5th, err=0 -> STATUS[0]=1, LEN=5; data reads at offsets 0x0..0x10 return 0x11..0x15.
- Frame with err=1 on last -> no slot set, DROPS=1, write slot unchanged.
- Fill all 4 slots, send a 5th frame -> DROPS increments. Release -> head=1, STATUS[0]=0, and the next frame lands in slot 0.
- Frame of C_DEPTH+3 words -> truncated, DROPS+1, no commit; the following 2-word frame commits with LEN=2.
- Last word arrives in the same cycle as the RELEASE write accept -> both take effect, full count unchanged.
- Release with all slots empty -> bresp=SLVERR. With ETH_RX_IRQ_EN, irq=0 at reset and 1 one cycle after the first commit.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet receive frame buffer.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DISCARD
  } wr_state_e;

  localparam logic [3:0] REG_STATUS  = 4'h0;
  localparam logic [3:0] REG_LEN     = 4'h4;
  localparam logic [3:0] REG_RELEASE = 4'h8;
  localparam logic [3:0] REG_DROPS   = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/eth_rx_slot_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
module eth_rx_slot_ram #(
  parameter int DW = 32,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // NOTE: the array has no reset so it maps onto block RAM; software only reads committed words.
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // NOTE: non-blocking assignments keep read-during-write returning the old word, as the RAM does.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/eth_rx_frame_buf.sv
// Multi-slot Ethernet RX frame buffer with AXI4-Lite access.
// Define ETH_RX_IRQ_EN to get a registered frame-available interrupt; otherwise irq is 0.
module eth_rx_frame_buf
  import eth_rx_pkg::*;
#(
  parameter  int C_DATA_WIDTH = 32,
  parameter  int C_DEPTH      = 512,
  parameter  int C_NUM_SLOTS  = 4,
  localparam int C_ADDR_WIDTH = $clog2(C_NUM_SLOTS*C_DEPTH) + $clog2(C_DATA_WIDTH/8) + 1
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                s_axi_awprot,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                s_axi_arprot,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  input  logic [C_DATA_WIDTH-1:0]   eth_rx_data,
  input  logic                      eth_rx_valid,
  input  logic                      eth_rx_last,
  input  logic                      eth_rx_err,
  output logic                      irq
);

  localparam int SW    = $clog2(C_NUM_SLOTS);
  localparam int PW    = $clog2(C_DEPTH);
  localparam int LW    = PW + 1;
  localparam int BW    = $clog2(C_DATA_WIDTH/8);
  localparam int RAW   = SW + PW;
  localparam int OFF_W = C_ADDR_WIDTH - 1;

  logic clk, rst_n;
  assign clk   = s_axi_aclk;
  assign rst_n = s_axi_aresetn;

  wr_state_e               state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [C_NUM_SLOTS-1:0]  full_q, full_d;
  logic [SW-1:0]           head_q, head_d, wslot_q, wslot_d;
  logic [LW-1:0]           len_q [C_NUM_SLOTS];
  logic [31:0]             drops_q;
  logic                    ram_we, commit, drop;
  logic [LW-1:0]           commit_len;

  logic                    awready_q, bvalid_q;
  logic [1:0]              bresp_q;
  logic                    wr_hs, rel_fire;

  logic                    arready_q, rd_pend_q, rvalid_q, rd_is_reg_q;
  logic [OFF_W-1:0]        rd_off_q;
  logic [C_DATA_WIDTH-1:0] rdata_q, reg_rdata, ram_rdata;
  logic [1:0]              rresp_q;
  logic                    reg_ok, ar_hs;

  // ---------------- Stream write FSM ----------------
  // ptr_q is held at 0 outside FILL, so the first word of a frame always lands at offset 0.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ram_we     = 1'b0;
    commit     = 1'b0;
    drop       = 1'b0;
    commit_len = LW'(ptr_q) + LW'(1);
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (eth_rx_valid) begin
          if (state_q == ST_IDLE && full_q[wslot_q]) begin
            drop = 1'b1;
            if (!eth_rx_last) state_d = ST_DISCARD;
          end else begin
            ram_we = 1'b1;
            if (eth_rx_last) begin
              ptr_d   = '0;
              state_d = ST_IDLE;
              if (eth_rx_err) drop   = 1'b1;
              else            commit = 1'b1;
            end else if (ptr_q == PW'(C_DEPTH-1)) begin
              ptr_d   = '0;
              state_d = ST_DISCARD;
              drop    = 1'b1;
            end else begin
              ptr_d   = ptr_q + PW'(1);
              state_d = ST_FILL;
            end
          end
        end
      end
      ST_DISCARD: if (eth_rx_valid && eth_rx_last) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Release clears before commit sets, so both land when they coincide.
  always_comb begin
    full_d  = full_q;
    head_d  = head_q;
    wslot_d = wslot_q;
    if (rel_fire) begin
      full_d[head_q] = 1'b0;
      head_d         = head_q + SW'(1);
    end
    if (commit) begin
      full_d[wslot_q] = 1'b1;
      wslot_d         = wslot_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      full_q  <= '0;
      head_q  <= '0;
      wslot_q <= '0;
      drops_q <= '0;
      for (int i = 0; i < C_NUM_SLOTS; i++) len_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      full_q  <= full_d;
      head_q  <= head_d;
      wslot_q <= wslot_d;
      if (commit) len_q[wslot_q] <= commit_len;
      if (drop && drops_q != '1) drops_q <= drops_q + 32'd1;
    end
  end

  eth_rx_slot_ram #(
    .DW (C_DATA_WIDTH),
    .AW (RAW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr ({wslot_q, ptr_q}),
    .wdata (eth_rx_data),
    .re    (ar_hs),
    .raddr (s_axi_araddr[BW +: RAW]),
    .rdata (ram_rdata)
  );

  // ---------------- AXI write channel ----------------
  assign wr_hs    = awready_q && s_axi_awvalid && s_axi_wvalid;
  assign rel_fire = wr_hs && s_axi_awaddr[C_ADDR_WIDTH-1]
                    && (s_axi_awaddr[OFF_W-1:0] == OFF_W'(REG_RELEASE)) && full_q[head_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      awready_q <= s_axi_awvalid && s_axi_wvalid && !awready_q && !bvalid_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= rel_fire ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;

  // ---------------- AXI read channel ----------------
  assign ar_hs = arready_q && s_axi_arvalid;

  always_comb begin
    reg_rdata = '0;
    reg_ok    = 1'b1;
    if (rd_off_q == OFF_W'(REG_STATUS)) begin
      reg_rdata[C_NUM_SLOTS-1:0] = full_q;
      reg_rdata[16 +: SW]        = head_q;
      reg_rdata[24 +: SW]        = wslot_q;
    end else if (rd_off_q == OFF_W'(REG_LEN)) begin
      reg_rdata[LW-1:0] = full_q[head_q] ? len_q[head_q] : '0;
    end else if (rd_off_q == OFF_W'(REG_DROPS)) begin
      reg_rdata[31:0] = drops_q;
    end else begin
      reg_ok = 1'b0;
    end
  end

  // Stage 1 issues the RAM read at the handshake; stage 2 registers RAM or register data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_is_reg_q <= 1'b0;
      rd_off_q    <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
    end else begin
      arready_q <= s_axi_arvalid && !arready_q && !rd_pend_q && !rvalid_q;
      rd_pend_q <= ar_hs;
      if (ar_hs) begin
        rd_is_reg_q <= s_axi_araddr[C_ADDR_WIDTH-1];
        rd_off_q    <= s_axi_araddr[OFF_W-1:0];
      end
      if (rd_pend_q) begin
        rvalid_q <= 1'b1;
        if (rd_is_reg_q) begin
          rdata_q <= reg_rdata;
          rresp_q <= reg_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
          rdata_q <= ram_rdata;
          rresp_q <= RESP_OKAY;
        end
      end else if (rvalid_q && s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

`ifdef ETH_RX_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= |full_d;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  logic unused_in;
  assign unused_in = ^{s_axi_awprot, s_axi_arprot, s_axi_wdata, s_axi_wstrb};

endmodule

// File: tb/tb_eth_rx_frame_buf.sv
// Self-checking bench for eth_rx_frame_buf: frame-level model plus literal pins.
module tb_eth_rx_frame_buf;

  localparam int DW    = 32;
  localparam int DEPTH = 512;
  localparam int NS    = 4;
  localparam int AW    = 14;
  localparam logic [AW-1:0] REG = 14'h2000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_last, rx_err, irq;

  always #5 clk = ~clk;

  eth_rx_frame_buf dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (awprot),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (arprot),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .eth_rx_data   (rx_data),
    .eth_rx_valid  (rx_valid),
    .eth_rx_last   (rx_last),
    .eth_rx_err    (rx_err),
    .irq           (irq)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level model: slot ring state and the words of every committed frame.
  logic [NS-1:0] m_full;
  int            m_len [NS];
  int            m_head, m_wr;
  logic [31:0]   m_drops;
  logic [31:0]   m_mem [NS][DEPTH];
  bit            mon_en = 1'b0;

  function automatic void model_reset();
    m_full = '0; m_head = 0; m_wr = 0; m_drops = 0;
    for (int i = 0; i < NS; i++) m_len[i] = 0;
  endfunction

  function automatic void model_frame(input int n, input logic [31:0] base, input bit err,
                                      input bit start_full);
    if (start_full || err || n > DEPTH) begin
      if (m_drops != 32'hFFFF_FFFF) m_drops++;
    end else begin
      for (int i = 0; i < n; i++) m_mem[m_wr][i] = base + 32'(i);
      m_len[m_wr]  = n;
      m_full[m_wr] = 1'b1;
      m_wr         = (m_wr + 1) % NS;
    end
  endfunction

  function automatic logic [1:0] model_write(input logic [AW-1:0] addr);
    if (addr == (REG | 14'h8) && m_full[m_head]) begin
      m_full[m_head] = 1'b0;
      m_head         = (m_head + 1) % NS;
      return 2'b00;
    end
    return 2'b10;
  endfunction

  function automatic void model_read(input logic [AW-1:0] addr, output logic [31:0] d,
                                     output logic [1:0] r);
    int wa;
    d = 0; r = 2'b00;
    if (addr[AW-1]) begin
      case (int'(addr[AW-2:0]))
        0:       d = 32'(m_full) | (32'(m_head) << 16) | (32'(m_wr) << 24);
        4:       d = m_full[m_head] ? 32'(m_len[m_head]) : 32'd0;
        12:      d = m_drops;
        default: r = 2'b10;
      endcase
    end else begin
      wa = int'(addr) >> 2;
      d  = m_mem[wa / DEPTH][wa % DEPTH];
    end
  endfunction

  function automatic logic exp_irq();
`ifdef ETH_RX_IRQ_EN
    return |m_full;
`else
    return 1'b0;
`endif
  endfunction

  always begin
    @(posedge clk);
    #3;
    if (rst_n && mon_en) check("irq", irq, exp_irq());
  end

  task automatic send_frame(input int n, input logic [31:0] base, input bit err);
    bit start_full;
    start_full = m_full[m_wr];
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_data  = base + 32'(i);
      rx_valid = 1'b1;
      rx_last  = (i == n - 1);
      rx_err   = (i == n - 1) ? err : 1'b0;
    end
    @(posedge clk);
    model_frame(n, base, err, start_full);
    @(negedge clk);
    rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input string name, output logic [1:0] resp);
    logic [1:0] exp_resp;
    int n;
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1; wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    n = 0;
    @(negedge clk);
    while (!awready && n < 8) begin @(negedge clk); n++; end
    check({name, " aw_lat"}, n, 0);
    check({name, " wready"}, wready, 1'b1);
    @(posedge clk);
    exp_resp = model_write(addr);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check({name, " bvalid"}, bvalid, 1'b1);
    check({name, " bresp"}, bresp, exp_resp);
    resp   = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check({name, " bvalid_clr"}, bvalid, 1'b0);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input string name, output logic [31:0] data);
    logic [31:0] ed;
    logic [1:0]  er;
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 8) begin @(negedge clk); n++; end
    check({name, " ar_lat"}, n, 0);
    @(posedge clk);
    model_read(addr, ed, er);
    @(negedge clk);
    arvalid = 1'b0;
    n = 1;
    while (!rvalid && n < 8) begin @(negedge clk); n++; end
    check({name, " r_lat"}, n, 2);
    check({name, " rdata"}, rdata, ed);
    check({name, " rresp"}, rresp, er);
    data = rdata;
    @(negedge clk);
    check({name, " r_hold"}, rvalid, 1'b1);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check({name, " r_clr"}, rvalid, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    bit          sf;
    awaddr = '0; awprot = '0; awvalid = 0; wvalid = 0; wdata = '0; wstrb = '0; bready = 0;
    araddr = '0; arprot = '0; arvalid = 0; rready = 0;
    rx_data = '0; rx_valid = 0; rx_last = 0; rx_err = 0;
    model_reset();

    repeat (2) @(negedge clk);
    check("rst awready", awready, 0);
    check("rst wready", wready, 0);
    check("rst bvalid", bvalid, 0);
    check("rst bresp", bresp, 0);
    check("rst arready", arready, 0);
    check("rst rvalid", rvalid, 0);
    check("rst rdata", rdata, 0);
    check("rst rresp", rresp, 0);
    check("rst irq", irq, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    axi_read(REG | 14'h0, "status0", d);  check("status0 lit", d, 32'h0);
    axi_read(REG | 14'hC, "drops0", d);   check("drops0 lit", d, 32'h0);
    axi_write(REG | 14'h8, "rel_empty", r); check("rel_empty lit", r, 2'b10);

    send_frame(5, 32'h11, 1'b0);
    axi_read(REG | 14'h0, "statusA", d);  check("statusA lit", d, 32'h0100_0001);
    axi_read(REG | 14'h4, "lenA", d);     check("lenA lit", d, 32'd5);
    for (int i = 0; i < 5; i++) begin
      axi_read(14'(i * 4), "dataA", d);
      check("dataA lit", d, 32'h11 + 32'(i));
    end

    send_frame(3, 32'h40, 1'b1);
    axi_read(REG | 14'h0, "status_err", d); check("status_err lit", d, 32'h0100_0001);
    axi_read(REG | 14'hC, "drops_err", d);  check("drops_err lit", d, 32'd1);

    send_frame(2, 32'h20, 1'b0);
    send_frame(3, 32'h30, 1'b0);
    send_frame(4, 32'h50, 1'b0);
    axi_read(REG | 14'h0, "status_full", d); check("status_full lit", d, 32'h0000_000F);
    send_frame(2, 32'h60, 1'b0);
    axi_read(REG | 14'hC, "drops_full", d);  check("drops_full lit", d, 32'd2);

    axi_write(REG | 14'h8, "rel1", r);
    axi_read(REG | 14'h0, "status_rel", d);  check("status_rel lit", d, 32'h0001_000E);
    axi_read(REG | 14'h4, "len_rel", d);     check("len_rel lit", d, 32'd2);
    send_frame(3, 32'h70, 1'b0);
    axi_read(REG | 14'h0, "status_s0", d);   check("status_s0 lit", d, 32'h0101_000F);
    axi_read(14'h8, "data_s0", d);           check("data_s0 lit", d, 32'h72);

    for (int i = 0; i < 4; i++) axi_write(REG | 14'h8, "rel_all", r);
    axi_read(REG | 14'h0, "status_emp", d);  check("status_emp lit", d, 32'h0101_0000);
    axi_read(REG | 14'h4, "len_emp", d);     check("len_emp lit", d, 32'd0);

    send_frame(DEPTH + 3, 32'h1000, 1'b0);
    axi_read(REG | 14'hC, "drops_trunc", d);  check("drops_trunc lit", d, 32'd3);
    axi_read(REG | 14'h0, "status_trunc", d); check("status_trunc lit", d, 32'h0101_0000);
    send_frame(2, 32'h80, 1'b0);
    axi_read(REG | 14'h0, "status_post", d);  check("status_post lit", d, 32'h0201_0002);
    axi_read(REG | 14'h4, "len_post", d);     check("len_post lit", d, 32'd2);
    axi_read(14'h804, "data_post", d);        check("data_post lit", d, 32'h81);

    // Last word and RELEASE accept share one clock edge.
    sf = m_full[m_wr];
    @(negedge clk);
    awaddr = REG | 14'h8; awvalid = 1'b1; wvalid = 1'b1;
    rx_data = 32'h90; rx_valid = 1'b1; rx_last = 1'b0; rx_err = 1'b0;
    @(negedge clk);
    check("conc awready", awready, 1'b1);
    rx_data = 32'h91; rx_last = 1'b1;
    @(posedge clk);
    r = model_write(REG | 14'h8);
    model_frame(2, 32'h90, 1'b0, sf);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; rx_valid = 1'b0; rx_last = 1'b0;
    check("conc bvalid", bvalid, 1'b1);
    check("conc bresp", bresp, r);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    axi_read(REG | 14'h0, "status_conc", d);  check("status_conc lit", d, 32'h0302_0004);
    axi_read(REG | 14'h4, "len_conc", d);     check("len_conc lit", d, 32'd2);
    axi_read(14'h1004, "data_conc", d);       check("data_conc lit", d, 32'h91);

    axi_read(REG | 14'h10, "unmapped", d);    check("unmapped lit", d, 32'h0);
    axi_read(REG | 14'h8, "rd_release", d);
    axi_write(REG | 14'h0, "wr_status", r);   check("wr_status lit", r, 2'b10);
    axi_write(14'h0, "wr_window", r);         check("wr_window lit", r, 2'b10);
    axi_read(REG | 14'h0, "status_noeff", d); check("status_noeff lit", d, 32'h0302_0004);

    // Partial frame interrupted by reset.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx_data = 32'hB0 + 32'(i); rx_valid = 1'b1; rx_last = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0; rx_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    axi_read(REG | 14'h0, "status_rst", d);   check("status_rst lit", d, 32'h0);
    send_frame(2, 32'hA0, 1'b0);
    axi_read(REG | 14'h0, "status_rf", d);    check("status_rf lit", d, 32'h0100_0001);
    axi_read(14'h4, "data_rf", d);            check("data_rf lit", d, 32'hA1);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
